seven_seg_scan_controller: RTL

Time-multiplexes four hex digits onto the board's shared 4-digit 7-segment display by sequencing the existing segment decoder. It drives the decoder's 2-bit digit-select, 4-bit nibble and dot inputs from a free-running refresh divider. It holds a double-buffered digit image: upstream logic loads a new image through a valid/ready handshake, and the controller commits it only at a frame boundary, so no digit ever shows mixed old/new data.

---
 rtl/seven_seg_scan_controller_if.sv | 22 ++
 rtl/seven_seg_scan_controller.sv | 122 ++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_controller_if.sv
// Image-load handshake between upstream logic and the scan controller.
// The master presents an image; the slave accepts it with LOAD_READY.
interface seven_seg_scan_controller_if;
  logic        LOAD_VALID;
  logic        LOAD_READY;
  logic [15:0] DIGITS_IN;
  logic [3:0]  DOTS_IN;

  modport master (
    output LOAD_VALID,
    output DIGITS_IN,
    output DOTS_IN,
    input  LOAD_READY
  );

  modport slave (
    input  LOAD_VALID,
    input  DIGITS_IN,
    input  DOTS_IN,
    output LOAD_READY
  );
endinterface

// File: rtl/seven_seg_scan_controller.sv
// Four-digit 7-segment scan sequencer with a double-buffered image.
// A pending image is committed to the active one only at frame end.
module seven_seg_scan_controller #(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic                         CLK,
  input  logic                         RESET,
  seven_seg_scan_controller_if.slave   load,
  output logic [1:0]                   SEG_SELECT_OUT,
  output logic [3:0]                   BIN_OUT,
  output logic                         DOT_OUT,
  output logic                         FRAME_DONE
);

  localparam int unsigned CW =
    (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } buf_state_e;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   act_dig_q, act_dig_d;
  logic [3:0]    act_dot_q, act_dot_d;
  logic [15:0]   pnd_dig_q, pnd_dig_d;
  logic [3:0]    pnd_dot_q, pnd_dot_d;
  buf_state_e    state_q, state_d;

  logic tc;
  logic frame_end;
  logic ready;

  always_comb begin
    tc        = (cnt_q == CNT_MAX);
    frame_end = tc & (idx_q == 2'd3);
    cnt_d     = tc ? '0 : cnt_q + CW'(1);
    idx_d     = tc ? idx_q + 2'd1 : idx_q;
  end

  // Capture in EMPTY even on frame end: the new image waits a frame.
  always_comb begin
    state_d   = state_q;
    ready     = 1'b0;
    act_dig_d = act_dig_q;
    act_dot_d = act_dot_q;
    pnd_dig_d = pnd_dig_q;
    pnd_dot_d = pnd_dot_q;
    unique case (state_q)
      EMPTY: begin
        ready = 1'b1;
        if (load.LOAD_VALID) begin
          pnd_dig_d = load.DIGITS_IN;
          pnd_dot_d = load.DOTS_IN;
          state_d   = FULL;
        end
      end
      FULL: begin
        if (frame_end) begin
          act_dig_d = pnd_dig_q;
          act_dot_d = pnd_dot_q;
          state_d   = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt_q     <= '0;
      idx_q     <= 2'd0;
      act_dig_q <= 16'h0000;
      act_dot_q <= 4'h0;
      pnd_dig_q <= 16'h0000;
      pnd_dot_q <= 4'h0;
      state_q   <= EMPTY;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      act_dig_q <= act_dig_d;
      act_dot_q <= act_dot_d;
      pnd_dig_q <= pnd_dig_d;
      pnd_dot_q <= pnd_dot_d;
      state_q   <= state_d;
    end
  end

  always_comb begin
    BIN_OUT = act_dig_q[3:0];
    DOT_OUT = act_dot_q[0];
    unique case (idx_q)
      2'd0: begin
        BIN_OUT = act_dig_q[3:0];
        DOT_OUT = act_dot_q[0];
      end
      2'd1: begin
        BIN_OUT = act_dig_q[7:4];
        DOT_OUT = act_dot_q[1];
      end
      2'd2: begin
        BIN_OUT = act_dig_q[11:8];
        DOT_OUT = act_dot_q[2];
      end
      2'd3: begin
        BIN_OUT = act_dig_q[15:12];
        DOT_OUT = act_dot_q[3];
      end
      default: begin
        BIN_OUT = act_dig_q[3:0];
        DOT_OUT = act_dot_q[0];
      end
    endcase
  end

  assign SEG_SELECT_OUT  = idx_q;
  assign FRAME_DONE      = frame_end;
  assign load.LOAD_READY = ready;

endmodule
